// File: rtl/quad_encoder_ctr_if.sv
// Encoder counter bus: raw pins and controls in, count and status pulses out.
//   a, b        raw quadrature phases (asynchronous)
//   enable      1 = accumulated steps update value
//   load        parallel load strobe, load_value is the value loaded
//   value       current count
//   step_pulse  one-cycle pulse per detent step taken
//   direction   direction of last step (1 = up)
//   error       one-cycle pulse on an illegal (double-bit) transition
interface quad_encoder_ctr_if #(
  parameter int unsigned WIDTH = 8
);
  logic             a;
  logic             b;
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] value;
  logic             step_pulse;
  logic             direction;
  logic             error;

  modport master (
    output a, b, enable, load, load_value,
    input  value, step_pulse, direction, error
  );

  modport slave (
    input  a, b, enable, load, load_value,
    output value, step_pulse, direction, error
  );
endinterface

// File: rtl/quad_encoder_ctr.sv
// Quadrature rotary-encoder counter: synchronises and debounces A/B, decodes
// all four edges, groups quarter-steps into detents and updates a bounded
// (saturating or wrapping) count with parallel load and enable.
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    quad_encoder_ctr_if slave: pins/controls in, value/status out
module quad_encoder_ctr #(
  parameter int unsigned      WIDTH            = 8,
  parameter int unsigned      SYNC_STAGES      = 2,
  parameter int unsigned      DEBOUNCE_CYCLES  = 4,
  parameter int unsigned      STEPS_PER_DETENT = 1,
  parameter int unsigned      SATURATE         = 0,
  parameter logic [WIDTH-1:0] MIN_VALUE        = '0,
  parameter logic [WIDTH-1:0] MAX_VALUE        = {WIDTH{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  quad_encoder_ctr_if.slave  bus
);

  localparam int unsigned CNT_W     = $clog2(DEBOUNCE_CYCLES + 2);
  localparam int unsigned BLANK_LEN = SYNC_STAGES + DEBOUNCE_CYCLES + 2;
  localparam int unsigned BLANK_W   = $clog2(BLANK_LEN + 1);
  localparam int unsigned ACC_W     = 4;
  // Accumulator limits as two's-complement patterns
  localparam logic [ACC_W-1:0] ACC_POS = ACC_W'(STEPS_PER_DETENT);
  localparam logic [ACC_W-1:0] ACC_NEG = ~ACC_POS + ACC_W'(1);

  // Synchroniser chain, {a,b} per stage
  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [1:0]                  sync_out;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], {bus.a, bus.b}};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Startup blanking counter
  logic [BLANK_W-1:0] blank_q;
  logic               blank;

  always_ff @(posedge clk) begin
    if (reset)              blank_q <= BLANK_W'(BLANK_LEN);
    else if (blank_q != '0) blank_q <= blank_q - BLANK_W'(1);
  end

  assign blank = (blank_q != '0);

  // Per-input debounce filter
  logic [1:0] filt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_filt
    if (DEBOUNCE_CYCLES == 0) begin : g_pass
      assign filt[gi] = sync_out[gi];
    end else begin : g_deb
      logic [CNT_W-1:0] cnt_q;
      logic             lvl_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
          lvl_q <= 1'b0;
        end else if (blank) begin
          // Adopt whatever level the pin sits at without counting
          cnt_q <= '0;
          lvl_q <= sync_out[gi];
        end else if (sync_out[gi] == lvl_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt_q <= '0;
          lvl_q <= sync_out[gi];
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      assign filt[gi] = lvl_q;
    end
  end

  // Previous filtered state, tracked every cycle
  logic [1:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 2'b00;
    else       prev_q <= filt;
  end

  // Quarter-step decode on {prev, current}
  logic qs_up, qs_dn, illegal;

  always_comb begin
    qs_up   = 1'b0;
    qs_dn   = 1'b0;
    illegal = 1'b0;
    case ({prev_q, filt})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: qs_up   = 1'b1;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: qs_dn   = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
      default: ;
    endcase
    if (blank) begin
      qs_up   = 1'b0;
      qs_dn   = 1'b0;
      illegal = 1'b0;
    end
  end

  // Detent accumulator and value update
  logic [WIDTH-1:0] value_q, value_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             error_q, error_d;
  logic             step_up, step_dn;
  logic [ACC_W-1:0] acc_inc, acc_dec;

  assign acc_inc = acc_q + ACC_W'(1);
  assign acc_dec = acc_q - ACC_W'(1);

  always_comb begin
    value_d = value_q;
    acc_d   = acc_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    error_d = illegal;
    step_up = 1'b0;
    step_dn = 1'b0;

    if (bus.load) begin
      value_d = bus.load_value;
      acc_d   = '0;
    end else if (!bus.enable) begin
      acc_d = '0;
    end else begin
      if (qs_up) begin
        if (acc_inc == ACC_POS) begin
          step_up = 1'b1;
          acc_d   = '0;
        end else begin
          acc_d = acc_inc;
        end
      end else if (qs_dn) begin
        if (acc_dec == ACC_NEG) begin
          step_dn = 1'b1;
          acc_d   = '0;
        end else begin
          acc_d = acc_dec;
        end
      end

      if (step_up) begin
        step_d = 1'b1;
        dir_d  = 1'b1;
        if (value_q == MAX_VALUE) value_d = (SATURATE != 0) ? value_q : MIN_VALUE;
        else                      value_d = value_q + WIDTH'(1);
      end else if (step_dn) begin
        step_d = 1'b1;
        dir_d  = 1'b0;
        if (value_q == MIN_VALUE) value_d = (SATURATE != 0) ? value_q : MAX_VALUE;
        else                      value_d = value_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= MIN_VALUE;
      acc_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      value_q <= value_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      error_q <= error_d;
    end
  end

  assign bus.value      = value_q;
  assign bus.step_pulse = step_q;
  assign bus.direction  = dir_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_quad_encoder_ctr.sv
// Bench for quad_encoder_ctr: three instances sharing the A/B pins
// (defaults, 4 steps per detent, saturating 0..200).
module tb_quad_encoder_ctr;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quad_encoder_ctr_if #(.WIDTH(8)) if0 ();
  quad_encoder_ctr_if #(.WIDTH(8)) if1 ();
  quad_encoder_ctr_if #(.WIDTH(8)) if2 ();

  quad_encoder_ctr u0 (.clk(clk), .reset(reset), .bus(if0));
  quad_encoder_ctr #(.STEPS_PER_DETENT(4)) u1 (.clk(clk), .reset(reset), .bus(if1));
  quad_encoder_ctr #(.SATURATE(1), .MAX_VALUE(8'd200)) u2 (.clk(clk), .reset(reset), .bus(if2));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected u0 steps
  typedef struct {
    logic [7:0] value;
    logic       dir;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  int err0 = 0;
  int sp1  = 0;
  int sp2  = 0;

  always @(negedge clk) begin
    if (if0.step_pulse === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_step", {24'd0, if0.value}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("step_value", {24'd0, if0.value}, {24'd0, e.value});
        check("step_dir", {31'd0, if0.direction}, {31'd0, e.dir});
        check("step_cycle", cyc, e.cyc);
      end
    end
    if (if0.error === 1'b1)      err0++;
    if (if1.step_pulse === 1'b1) sp1++;
    if (if2.step_pulse === 1'b1) sp2++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Reference models
  logic [7:0] m0, m1, m2;
  int         acc1, sp1_exp, sp2_exp, err_exp;
  bit         en_m0;

  task automatic set_pins(input logic pa, input logic pb);
    if0.a = pa; if1.a = pa; if2.a = pa;
    if0.b = pb; if1.b = pb; if2.b = pb;
  endtask

  task automatic model_step(input int d);
    if (en_m0 && d != 0) begin
      if (d > 0) m0 = (m0 == 8'd255) ? 8'd0 : m0 + 8'd1;
      else       m0 = (m0 == 8'd0) ? 8'd255 : m0 - 8'd1;
      sb.push_back('{value: m0, dir: (d > 0), cyc: cyc + 7});
    end
    acc1 += d;
    if (acc1 == 4)  begin acc1 = 0; m1 = m1 + 8'd1; sp1_exp++; end
    if (acc1 == -4) begin acc1 = 0; m1 = m1 - 8'd1; sp1_exp++; end
    if (d > 0) begin m2 = (m2 == 8'd200) ? m2 : m2 + 8'd1; sp2_exp++; end
    if (d < 0) begin m2 = (m2 == 8'd0) ? m2 : m2 - 8'd1; sp2_exp++; end
  endtask

  // Drive a new pin state at a falling edge, model it, hold
  task automatic qstep(input logic [1:0] ab, input int d, input int hold);
    @(negedge clk);
    set_pins(ab[1], ab[0]);
    model_step(d);
    repeat (hold) @(negedge clk);
  endtask

  task automatic apply_reset(input logic pa, input logic pb);
    @(negedge clk);
    reset = 1'b1;
    set_pins(pa, pb);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    m0 = 8'd0; m1 = 8'd0; m2 = 8'd0; acc1 = 0;
  endtask

  task automatic check_models(input string tag);
    check({tag, "_v0"}, {24'd0, if0.value}, {24'd0, m0});
    check({tag, "_v1"}, {24'd0, if1.value}, {24'd0, m1});
    check({tag, "_v2"}, {24'd0, if2.value}, {24'd0, m2});
    check({tag, "_sp1"}, sp1, sp1_exp);
    check({tag, "_sp2"}, sp2, sp2_exp);
    check({tag, "_err"}, err0, err_exp);
  endtask

  initial begin
    reset = 1'b1;
    en_m0 = 1'b1;
    sp1_exp = 0; sp2_exp = 0; err_exp = 0;
    if0.enable = 1'b1; if1.enable = 1'b1; if2.enable = 1'b1;
    if0.load = 1'b0;   if1.load = 1'b0;   if2.load = 1'b0;
    if0.load_value = '0; if1.load_value = '0; if2.load_value = '0;

    // Reset with pins at 11, then release and idle
    apply_reset(1'b1, 1'b1);
    check("rst_value", {24'd0, if0.value}, 32'd0);
    check("rst_step", {31'd0, if0.step_pulse}, 32'd0);
    check("rst_dir", {31'd0, if0.direction}, 32'd0);
    check("rst_err", {31'd0, if0.error}, 32'd0);
    repeat (20) @(negedge clk);
    check_models("idle11");

    // Restart from 00
    apply_reset(1'b0, 1'b0);
    repeat (20) @(negedge clk);

    // One CW cycle
    qstep(2'b10, 1, 10);
    qstep(2'b11, 1, 10);
    qstep(2'b01, 1, 10);
    qstep(2'b00, 1, 10);
    check_models("cw");
    check("cw_dir1", {31'd0, if1.direction}, 32'd1);

    // One CCW cycle
    qstep(2'b01, -1, 10);
    qstep(2'b11, -1, 10);
    qstep(2'b10, -1, 10);
    qstep(2'b00, -1, 10);
    check_models("ccw");
    check("ccw_dir1", {31'd0, if1.direction}, 32'd0);

    // Reversal mid-detent
    qstep(2'b10, 1, 10);
    qstep(2'b00, -1, 10);
    check_models("rev");

    // Loads at the range top
    @(negedge clk);
    if0.load = 1'b1; if0.load_value = 8'd255;
    if2.load = 1'b1; if2.load_value = 8'd200;
    @(negedge clk);
    if0.load = 1'b0; if2.load = 1'b0;
    m0 = 8'd255; m2 = 8'd200;
    check_models("load");

    qstep(2'b10, 1, 10);
    check_models("wrap_up");
    check("sat_dir", {31'd0, if2.direction}, 32'd1);
    qstep(2'b00, -1, 10);
    check_models("wrap_dn");

    // Three-cycle glitch on a
    @(negedge clk);
    set_pins(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    set_pins(1'b0, 1'b0);
    repeat (12) @(negedge clk);
    check_models("glitch");

    // Illegal jumps 00->11 and back
    err_exp = 1;
    qstep(2'b11, 0, 12);
    check_models("illegal1");
    err_exp = 2;
    qstep(2'b00, 0, 12);
    check_models("illegal2");

    // Load coinciding with a resolving step
    @(negedge clk);
    set_pins(1'b1, 1'b0);
    en_m0 = 1'b0;
    model_step(1);
    en_m0 = 1'b1;
    repeat (6) @(negedge clk);
    if0.load = 1'b1; if0.load_value = 8'h42;
    @(negedge clk);
    if0.load = 1'b0;
    m0 = 8'h42;
    repeat (4) @(negedge clk);
    check_models("load_step");

    // Quarter-steps discarded while disabled
    if0.enable = 1'b0;
    en_m0 = 1'b0;
    qstep(2'b11, 1, 10);
    qstep(2'b01, 1, 10);
    qstep(2'b00, 1, 10);
    @(negedge clk);
    if0.enable = 1'b1;
    en_m0 = 1'b1;
    repeat (10) @(negedge clk);
    check_models("disabled");

    check("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
